// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: one instruction-fetch port and one load/store port
// share a single combinational-read, clocked-write memory, one access at a time.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_data,
  input  logic        d_req_valid,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  input  logic        d_req_we,
  output logic        d_req_ready,
  output logic        d_resp_valid,
  output logic [31:0] d_resp_data,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data,
  output logic [1:0]  dbg_state,
  output logic [1:0]  dbg_starve_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  starve_cnt;
  logic        lat_is_d;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        in_idle;
  logic        grant_d;
  logic        grant_i;

  // Handshake: a request transfers in the cycle where valid and ready are both
  // high; ready depends only on state and the current valids, and the
  // requester keeps valid/address stable until that transfer.
  always_comb begin
    in_idle = 1'b0;
    grant_d = 1'b0;
    grant_i = 1'b0;
    in_idle = rst_n && (state == IDLE);
    grant_d = in_idle && d_req_valid && (!if_req_valid || (starve_cnt != 2'd3));
    grant_i = in_idle && if_req_valid && !grant_d;
  end

  assign if_req_ready     = grant_i;
  assign d_req_ready      = grant_d;
  assign mem_address      = lat_addr;
  assign mem_write_data   = lat_wdata;
  assign mem_write_enable = (state == ACCESS) && lat_we;
  assign dbg_state        = state;
  assign dbg_starve_cnt   = starve_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      starve_cnt    <= 2'd0;
      lat_is_d      <= 1'b0;
      lat_we        <= 1'b0;
      lat_addr      <= 32'd0;
      lat_wdata     <= 32'd0;
      if_resp_valid <= 1'b0;
      if_resp_data  <= 32'd0;
      d_resp_valid  <= 1'b0;
      d_resp_data   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= ACCESS;
            lat_is_d  <= 1'b1;
            lat_addr  <= d_req_addr;
            lat_wdata <= d_req_wdata;
            lat_we    <= d_req_we;
            // Only a data win over a waiting fetch counts toward starvation.
            if (if_req_valid && (starve_cnt != 2'd3))
              starve_cnt <= starve_cnt + 2'd1;
          end else if (grant_i) begin
            state      <= ACCESS;
            lat_is_d   <= 1'b0;
            lat_addr   <= if_req_addr;
            lat_we     <= 1'b0;
            starve_cnt <= 2'd0;
          end
        end
        ACCESS: begin
          state <= RESP;
          if (lat_is_d) begin
            d_resp_valid <= 1'b1;
            d_resp_data  <= lat_we ? 32'd0 : mem_read_data;
          end else begin
            if_resp_valid <= 1'b1;
            if_resp_data  <= mem_read_data;
          end
        end
        RESP: begin
          state         <= IDLE;
          if_resp_valid <= 1'b0;
          d_resp_valid  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: behavioural memory, hand-computed expectations,
// immediate assertions at every comparison point.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [31:0] if_resp_data;
  logic        d_req_valid;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic        d_req_we;
  logic        d_req_ready;
  logic        d_resp_valid;
  logic [31:0] d_resp_data;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_starve_cnt;

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;

  logic [31:0] mem [0:255];
  logic [1:0]  s_seq [4];
  logic [31:0] bb_addr [3];
  logic [31:0] bb_data [3];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_req_we(d_req_we), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  assign mem_read_data = mem[mem_address[9:2]];

  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[mem_address[9:2]] <= mem_write_data;
      we_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // One complete request on one port, starting just after a rising edge in IDLE.
  task automatic txn(input bit is_d, input logic [31:0] addr, input logic [31:0] wdata,
                     input bit we, input logic [31:0] exp_data);
    int w0;
    w0 = we_cnt;
    if (is_d) begin
      d_req_valid = 1'b1; d_req_addr = addr; d_req_wdata = wdata; d_req_we = we;
    end else begin
      if_req_valid = 1'b1; if_req_addr = addr;
    end
    @(negedge clk);
    chk("txn_ready_win", is_d ? d_req_ready : if_req_ready, 32'd1);
    chk("txn_ready_lose", is_d ? if_req_ready : d_req_ready, 32'd0);
    cyc;
    d_req_valid = 1'b0;
    if_req_valid = 1'b0;
    @(negedge clk);
    chk("txn_state_access", dbg_state, 32'd1);
    chk("txn_mem_address", mem_address, addr);
    chk("txn_mem_we", mem_write_enable, we);
    if (is_d) chk("txn_mem_wdata", mem_write_data, wdata);
    chk("txn_resp_early", is_d ? d_resp_valid : if_resp_valid, 32'd0);
    cyc;
    @(negedge clk);
    chk("txn_resp_valid", is_d ? d_resp_valid : if_resp_valid, 32'd1);
    chk("txn_resp_data", is_d ? d_resp_data : if_resp_data, exp_data);
    chk("txn_other_resp", is_d ? if_resp_valid : d_resp_valid, 32'd0);
    cyc;
    @(negedge clk);
    chk("txn_resp_pulse_end", is_d ? d_resp_valid : if_resp_valid, 32'd0);
    chk("txn_state_idle", dbg_state, 32'd0);
    chk("txn_resp_hold", is_d ? d_resp_data : if_resp_data, exp_data);
    chk("txn_write_count", we_cnt - w0, we ? 32'd1 : 32'd0);
    cyc;
  endtask

  initial begin
    int w0;
    logic [31:0] prev;
    bit exp_d;

    for (int i = 0; i < 256; i++) mem[i] = 32'h01010101 * i;
    mem[4]  = 32'h00500093;
    mem[5]  = 32'h00A00113;
    mem[6]  = 32'h00B00193;
    mem[16] = 32'h00000000;
    mem[32] = 32'hCAFEF00D;
    s_seq   = '{2'd1, 2'd2, 2'd3, 2'd0};
    bb_addr = '{32'h10, 32'h14, 32'h18};
    bb_data = '{32'h00500093, 32'h00A00113, 32'h00B00193};

    // Reset with both requesters asserting valid: nothing may be granted.
    rst_n = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    d_req_valid = 1'b1; d_req_addr = 32'h40; d_req_wdata = 32'h0; d_req_we = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_if_ready", if_req_ready, 32'd0);
    chk("rst_d_ready", d_req_ready, 32'd0);
    chk("rst_if_resp_valid", if_resp_valid, 32'd0);
    chk("rst_d_resp_valid", d_resp_valid, 32'd0);
    chk("rst_mem_we", mem_write_enable, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    chk("rst_if_resp_data", if_resp_data, 32'd0);
    chk("rst_d_resp_data", d_resp_data, 32'd0);
    chk("rst_state", dbg_state, 32'd0);
    chk("rst_starve", dbg_starve_cnt, 32'd0);
    if_req_valid = 1'b0;
    d_req_valid = 1'b0;
    cyc;
    rst_n = 1'b1;

    // Fetch in the very first IDLE cycle after reset.
    txn(1'b0, 32'h10, 32'h0, 1'b0, 32'h00500093);

    // Store then load, and an unaligned load passed through unmodified.
    txn(1'b1, 32'h40, 32'hDEADBEEF, 1'b1, 32'h0);
    chk("store_mem_content", mem[16], 32'hDEADBEEF);
    txn(1'b1, 32'h40, 32'h0, 1'b0, 32'hDEADBEEF);
    txn(1'b1, 32'h43, 32'h0, 1'b0, 32'hDEADBEEF);

    // Simultaneous first request: data first, fetch at N+3.
    d_req_valid = 1'b1; d_req_addr = 32'h40; d_req_we = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h14;
    @(negedge clk);
    chk("sim_d_ready", d_req_ready, 32'd1);
    chk("sim_if_ready", if_req_ready, 32'd0);
    cyc;
    d_req_valid = 1'b0;
    chk("sim_starve_1", dbg_starve_cnt, 32'd1);
    @(negedge clk);
    chk("sim_if_ready_access", if_req_ready, 32'd0);
    cyc;
    @(negedge clk);
    chk("sim_d_resp_valid", d_resp_valid, 32'd1);
    chk("sim_d_resp_data", d_resp_data, 32'hDEADBEEF);
    chk("sim_if_resp_idle", if_resp_valid, 32'd0);
    chk("sim_if_ready_resp", if_req_ready, 32'd0);
    cyc;
    @(negedge clk);
    chk("sim_if_ready_n3", if_req_ready, 32'd1);
    cyc;
    if_req_valid = 1'b0;
    chk("sim_starve_clear", dbg_starve_cnt, 32'd0);
    cyc;
    @(negedge clk);
    chk("sim_if_resp_valid", if_resp_valid, 32'd1);
    chk("sim_if_resp_data", if_resp_data, 32'h00A00113);
    cyc;

    // Continuous contention: grant order D,D,D,I repeating.
    d_req_valid = 1'b1; d_req_addr = 32'h40; d_req_we = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h18;
    for (int g = 0; g < 8; g++) begin
      exp_d = ((g % 4) != 3);
      @(negedge clk);
      chk("cont_d_ready", d_req_ready, exp_d);
      chk("cont_if_ready", if_req_ready, !exp_d);
      cyc;
      chk("cont_starve", dbg_starve_cnt, s_seq[g % 4]);
      @(negedge clk);
      chk("cont_access_no_ready", {if_req_ready, d_req_ready}, 32'd0);
      cyc;
      @(negedge clk);
      chk("cont_d_resp", d_resp_valid, exp_d);
      chk("cont_if_resp", if_resp_valid, !exp_d);
      cyc;
    end
    d_req_valid = 1'b0;
    if_req_valid = 1'b0;

    // Back-to-back fetches with valid held high throughout.
    prev = 32'h00B00193;
    if_req_valid = 1'b1; if_req_addr = bb_addr[0];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("b2b_ready", if_req_ready, 32'd1);
      cyc;
      if (k < 2) if_req_addr = bb_addr[k + 1];
      @(negedge clk);
      chk("b2b_no_resp_access", if_resp_valid, 32'd0);
      chk("b2b_data_stable", if_resp_data, prev);
      cyc;
      @(negedge clk);
      chk("b2b_resp_valid", if_resp_valid, 32'd1);
      chk("b2b_resp_data", if_resp_data, bb_data[k]);
      prev = bb_data[k];
      cyc;
    end
    if_req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_pulse_end", if_resp_valid, 32'd0);
    chk("b2b_data_hold", if_resp_data, 32'h00B00193);
    cyc;

    // Reset asserted during the ACCESS cycle of a store.
    w0 = we_cnt;
    d_req_valid = 1'b1; d_req_addr = 32'h80; d_req_wdata = 32'h12345678; d_req_we = 1'b1;
    @(negedge clk);
    chk("rms_d_ready", d_req_ready, 32'd1);
    cyc;
    @(negedge clk);
    chk("rms_we_before", mem_write_enable, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rms_we_after", mem_write_enable, 32'd0);
    chk("rms_state", dbg_state, 32'd0);
    chk("rms_d_ready", d_req_ready, 32'd0);
    chk("rms_mem_address", mem_address, 32'd0);
    chk("rms_mem_wdata", mem_write_data, 32'd0);
    chk("rms_if_resp_data", if_resp_data, 32'd0);
    chk("rms_d_resp_data", d_resp_data, 32'd0);
    d_req_valid = 1'b0;
    d_req_we = 1'b0;
    repeat (2) cyc;
    @(negedge clk);
    chk("rms_mem_unchanged", mem[32], 32'hCAFEF00D);
    chk("rms_no_write", we_cnt - w0, 32'd0);
    chk("rms_no_resp_in_reset", d_resp_valid, 32'd0);
    cyc;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rms_no_resp_after", d_resp_valid, 32'd0);
    cyc;
    txn(1'b0, 32'h14, 32'h0, 1'b0, 32'h00A00113);
    chk("rms_mem_final", mem[32], 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 One clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 if_req_valid  in  1  fetch request present.
REQ-005 if_req_addr  in  32  fetch byte address.
REQ-006 if_req_ready  out  1  fetch request accepted this cycle when high with if_req_valid.
REQ-007 if_resp_valid  out  1  one-cycle pulse, fetch data valid.
REQ-008 if_resp_data  out  32  fetched word, little-endian.
REQ-009 d_req_valid  in  1  data request present.
REQ-010 d_req_addr  in  32  data byte address.
REQ-011 d_req_wdata  in  32  store data.
REQ-012 d_req_we  in  1  1 = store, 0 = load.
REQ-013 d_req_ready  out  1  data request accepted this cycle when high with d_req_valid.
REQ-014 d_resp_valid  out  1  one-cycle pulse, load data valid or store acknowledged.
REQ-015 d_resp_data  out  32  loaded word; 0 for store acknowledge.
REQ-016 mem_address  out  32  to the byte-addressed memory; read path is combinational.
REQ-017 mem_write_data  out  32  to memory.
REQ-018 mem_write_enable  out  1  to memory; memory writes 4 bytes at mem_address on clk rising edge.
REQ-019 mem_read_data  in  32  combinational memory read of mem_address.

Function
REQ-020 FSM states: IDLE, ACCESS, RESP; transitions IDLE->ACCESS on any accepted request, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-021 Ready: if_req_ready and d_req_ready are combinational and may be high only in IDLE; at most one is high per cycle, selected by the arbitration rule; a ready is high only toward a requester whose valid is high.
REQ-022 Arbitration in IDLE: only one valid requester wins; if both are valid, data wins unless starve_cnt == 3, in which case fetch wins.
REQ-023 starve_cnt (2 bits): on data winning while if_req_valid=1, increment saturating at 3; on fetch winning, clear to 0; otherwise hold.
REQ-024 On acceptance, register the winner id, address, wdata and we (we forced to 0 for fetch).
REQ-025 In ACCESS: mem_address = latched address; mem_write_data = latched wdata; mem_write_enable = latched we; for a load/fetch, capture mem_read_data into the winner's response register at the end of the cycle.
REQ-026 Outside ACCESS: mem_write_enable = 0; mem_address and mem_write_data hold their last latched values.
REQ-027 In RESP: the winner's resp_valid = 1 for exactly one cycle; the other resp_valid = 0.
REQ-028 Latency: a request accepted in cycle N gets resp_valid in cycle N+2; the next acceptance is possible in cycle N+3.
REQ-029 Store acknowledge: d_resp_data = 0 in the RESP cycle of a store.
REQ-030 Response data registers hold their value until overwritten by the next response to the same port.
REQ-031 Addresses are passed unmodified; alignment is not checked.
REQ-032 Requests arriving outside IDLE are ignored; requesters hold valid and address until accepted.

Reset
REQ-033 While rst_n = 0: state = IDLE; starve_cnt = 0; all ready, resp_valid and mem_write_enable = 0; mem_address, mem_write_data, if_resp_data and d_resp_data = 0.
REQ-034 Reset asserted in ACCESS or RESP aborts the access: no write occurs after assertion and no resp_valid is produced.
REQ-035 After deassertion, the first acceptance is possible in the first IDLE cycle.

Verification
REQ-036 Fetch only: if_req_addr = 0x10, memory word 0x00500093 -> ready in cycle N, if_resp_valid in N+2, if_resp_data = 0x00500093, no write.
REQ-037 Store then load: store 0xDEADBEEF to 0x40, then load 0x40 -> mem_write_enable high for exactly 1 cycle, d_resp_data = 0 then 0xDEADBEEF.
REQ-038 Contention: both valid continuously -> grant order D, D, D, I, D, D, D, I...; starve_cnt sequence 1, 2, 3, 0.
REQ-039 Simultaneous first request with starve_cnt = 0 -> data granted; fetch granted in cycle N+3.
REQ-040 Reset mid-store (rst_n low during ACCESS) -> memory location unchanged, all outputs 0, fresh fetch succeeds after release.
REQ-041 Back-to-back fetches -> accepted every 3 cycles, resp_valid pulses exactly one cycle, if_resp_data stable between pulses.
